// File: rtl/sched_pkg.sv
// Shared constants and FSM state type for the priority scheduler.
package sched_pkg;

  localparam int NUM_PRIO     = 8;
  localparam int PRIO_WIDTH   = 3;
  localparam int WEIGHT_WIDTH = 4;
  localparam int STARVE_LIMIT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_t;

  // WRR weight of queue idx; higher index earns proportionally more grants.
  function automatic int weight_of(input int idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Masked round-robin picker: one-hot grant to the first set req bit found
// searching upward from last+1, wrapping past the top index.
module rr_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] grant
);

  // Linear wrap-around search; first hit wins.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[W'(idx)]) begin
        found            = 1'b1;
        grant[W'(idx)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_sched.sv
// Per-port packet scheduler: strict priority or weighted round robin over
// NUM_PRIO queues, holding the grant for a whole packet.
// Optional feature macro: SCHED_STARVE_GUARD_EN (anti-starvation bypass
// counters that override strict priority for long-waiting queues).
//
//   state | meaning
//   IDLE  | no packet in flight; arbitrate when any queue is non-empty
//   XFER  | granted queue popped on out_rdy until its EOP word leaves
module prio_sched #(
  parameter int NUM_PRIO     = sched_pkg::NUM_PRIO,
  parameter int PRIO_WIDTH   = sched_pkg::PRIO_WIDTH,
  parameter int WEIGHT_WIDTH = sched_pkg::WEIGHT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sp0_wrr1,
  input  logic [NUM_PRIO-1:0]   q_empty,
  input  logic [NUM_PRIO-1:0]   q_eop,
  input  logic                  out_rdy,
  output logic [NUM_PRIO-1:0]   rd_en,
  output logic [PRIO_WIDTH-1:0] sel_prio,
  output logic                  busy,
  output logic                  pkt_done
);
  import sched_pkg::*;

  sched_state_t              state;
  logic [PRIO_WIDTH-1:0]     rr_ptr;
  logic [WEIGHT_WIDTH-1:0]   credit [NUM_PRIO];

  logic [NUM_PRIO-1:0]       nonempty;
  logic [NUM_PRIO-1:0]       has_credit;
  logic [NUM_PRIO-1:0]       wrr_req;
  logic [NUM_PRIO-1:0]       wrr_grant;
  logic                      credit_reload;
  logic [PRIO_WIDTH-1:0]     sp_idx;
  logic [PRIO_WIDTH-1:0]     wrr_idx;
  logic [PRIO_WIDTH-1:0]     win_idx;
  logic                      arb_fire;

  // Weights are i+1 and must fit WEIGHT_WIDTH (max NUM_PRIO).
  function automatic logic [WEIGHT_WIDTH-1:0] weight(input int idx);
    return WEIGHT_WIDTH'(weight_of(idx));
  endfunction

`ifdef SCHED_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] byp_cnt [NUM_PRIO];
`endif

  // WRR eligibility; when nobody non-empty has credit, arbitrate as if reloaded.
  always_comb begin
    nonempty = ~q_empty;
    for (int i = 0; i < NUM_PRIO; i++) begin
      has_credit[i] = (credit[i] != '0);
    end
    credit_reload = ~|(nonempty & has_credit);
    wrr_req       = credit_reload ? nonempty : (nonempty & has_credit);
  end

  rr_pick #(
    .N (NUM_PRIO),
    .W (PRIO_WIDTH)
  ) u_rr_pick (
    .req   (wrr_req),
    .last  (rr_ptr),
    .grant (wrr_grant)
  );

  // One-hot WRR grant to index.
  always_comb begin
    wrr_idx = '0;
    for (int i = 0; i < NUM_PRIO; i++) begin
      if (wrr_grant[i]) wrr_idx = PRIO_WIDTH'(i);
    end
  end

  // Strict priority: highest non-empty index, unless a starved queue overrides.
  always_comb begin
`ifdef SCHED_STARVE_GUARD_EN
    logic                  any_starved;
    logic [PRIO_WIDTH-1:0] starved_idx;
    any_starved = 1'b0;
    starved_idx = '0;
`endif
    sp_idx = '0;
    for (int i = 0; i < NUM_PRIO; i++) begin
      if (nonempty[i]) sp_idx = PRIO_WIDTH'(i);
`ifdef SCHED_STARVE_GUARD_EN
      if (nonempty[i] && (byp_cnt[i] == STARVE_W'(STARVE_LIMIT))) begin
        any_starved = 1'b1;
        starved_idx = PRIO_WIDTH'(i);
      end
`endif
    end
`ifdef SCHED_STARVE_GUARD_EN
    if (any_starved) sp_idx = starved_idx;
`endif
  end

  assign win_idx  = sp0_wrr1 ? wrr_idx : sp_idx;
  assign arb_fire = (state == IDLE) && (|nonempty);

  // Pop strobe is combinational so a stalled or back-pressured word is never popped.
  always_comb begin
    rd_en = '0;
    if (state == XFER) rd_en[sel_prio] = out_rdy & ~q_empty[sel_prio];
  end

  assign pkt_done = rd_en[sel_prio] & q_eop[sel_prio];
  assign busy     = (state == XFER);

  // Packet FSM: latch winner in IDLE, hold grant until EOP pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_prio <= '0;
      rr_ptr   <= PRIO_WIDTH'(NUM_PRIO - 1);
    end else begin
      case (state)
        IDLE: begin
          if (arb_fire) begin
            sel_prio <= win_idx;
            state    <= XFER;
            if (sp0_wrr1) rr_ptr <= wrr_idx;
          end
        end
        XFER: begin
          if (pkt_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // WRR credits: winner pays one per packet; reload happens in the arbitration cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PRIO; i++) credit[i] <= weight(i);
    end else if (arb_fire && sp0_wrr1) begin
      for (int i = 0; i < NUM_PRIO; i++) begin
        if (credit_reload) begin
          credit[i] <= (PRIO_WIDTH'(i) == wrr_idx) ? weight(i) - WEIGHT_WIDTH'(1)
                                                   : weight(i);
        end else if ((PRIO_WIDTH'(i) == wrr_idx) && has_credit[i]) begin
          credit[i] <= credit[i] - WEIGHT_WIDTH'(1);
        end
      end
    end
  end

`ifdef SCHED_STARVE_GUARD_EN
  // Bypass counters: count arbitrations lost while waiting, saturate at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PRIO; i++) byp_cnt[i] <= '0;
    end else if (arb_fire) begin
      for (int i = 0; i < NUM_PRIO; i++) begin
        if (PRIO_WIDTH'(i) == win_idx) begin
          byp_cnt[i] <= '0;
        end else if (nonempty[i] && (byp_cnt[i] != STARVE_W'(STARVE_LIMIT))) begin
          byp_cnt[i] <= byp_cnt[i] + STARVE_W'(1);
        end
      end
    end
  end
`endif

endmodule
